// File: rtl/irq_request_ctrl.sv
// irq_request_ctrl: synchronises and edge/level-detects an external interrupt
// pin, holds one pending request and raises intr to the fetch unit at a safe
// instruction boundary. The request is dropped on int_clr and nesting is
// blocked until the handler's RTI retires (rti_done).
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   irq_in           external interrupt pin (asynchronous)
//   int_en           global interrupt enable
//   boundary         fetch unit at a single-word instruction boundary
//   stall_in         pipeline stall, blocks issuing a request
//   int_clr          fetch unit acknowledge (vector load done)
//   rti_done         one-cycle pulse when RTI retires
//   intr             interrupt request to the fetch unit
//   in_service       handler currently executing
//   pending          an un-issued request is latched
//   lost_cnt         saturating count of coalesced/dropped events
module irq_request_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 1,
    parameter int LOST_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              irq_in,
    input  logic              int_en,
    input  logic              boundary,
    input  logic              stall_in,
    input  logic              int_clr,
    input  logic              rti_done,
    output logic              intr,
    output logic              in_service,
    output logic              pending,
    output logic [LOST_W-1:0] lost_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        REQ     = 2'd2,
        SERVICE = 2'd3
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;
    logic                   r_q;
    logic                   r_intr;
    logic                   r_in_service;
    logic                   r_pending;
    logic [LOST_W-1:0]      r_lost;

    logic                   w_s;
    logic                   w_event;
    logic                   w_issue;
    logic                   w_lost_inc;

    assign w_s     = r_sync[SYNC_STAGES-1];
    assign w_issue = int_en & boundary & ~stall_in;

    // Level mode only samples the pin when a new request may be accepted:
    // in IDLE, or at the RTI retire cycle (re-arm if still asserted).
    always_comb begin
        w_event = 1'b0;
        if (EDGE_MODE != 0) begin
            w_event = w_s & ~r_s_d;
        end else begin
            w_event = w_s & ((r_state == IDLE) |
                             ((r_state == SERVICE) & rti_done));
        end
    end

    // An event is lost when no slot is free to hold it.
    always_comb begin
        w_lost_inc = 1'b0;
        unique case (r_state)
            ARMED:   w_lost_inc = w_event;
            REQ:     w_lost_inc = w_event;
            SERVICE: w_lost_inc = w_event & r_q;
            default: w_lost_inc = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], irq_in};
            r_s_d  <= w_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lost <= '0;
        end else if (w_lost_inc && (r_lost != {LOST_W{1'b1}})) begin
            r_lost <= r_lost + {{(LOST_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_q          <= 1'b0;
            r_intr       <= 1'b0;
            r_in_service <= 1'b0;
            r_pending    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_event) begin
                        r_state   <= ARMED;
                        r_pending <= 1'b1;
                    end
                end
                ARMED: begin
                    if (w_issue) begin
                        r_state <= REQ;
                        r_intr  <= 1'b1;
                    end
                end
                REQ: begin
                    // Once raised, the request is held until acknowledged.
                    if (int_clr) begin
                        r_state      <= SERVICE;
                        r_intr       <= 1'b0;
                        r_pending    <= 1'b0;
                        r_in_service <= 1'b1;
                    end
                end
                SERVICE: begin
                    if (rti_done) begin
                        r_in_service <= 1'b0;
                        if (r_q) begin
                            r_state <= ARMED;
                            r_q     <= 1'b0;
                        end else if (w_event) begin
                            r_state   <= ARMED;
                            r_pending <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (w_event && !r_q) begin
                        r_q       <= 1'b1;
                        r_pending <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Masked so a request is never visible in a reset cycle.
    assign intr       = r_intr & ~reset;
    assign in_service = r_in_service;
    assign pending    = r_pending;
    assign lost_cnt   = r_lost;

endmodule

// File: doc/irq_request_ctrl.md
Name: irq_request_ctrl

Overview:
- Interrupt-request side of the fetch-stage interrupt handshake.
- Synchronises and edge-detects an external interrupt pin and holds one request pending.
- Raises `intr` to the fetch control unit only at a safe instruction boundary, drops it when the fetch unit answers with `int_clr`, then blocks nesting until the handler's RTI completes.
- Sits between the external pin / software enable and the fetch-stage control unit.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the `irq_in` synchroniser (≥2).
- EDGE_MODE, 1, 1 = rising-edge triggered, 0 = level triggered.
- LOST_W, 4, width of the saturating lost-interrupt counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- irq_in  in  1  external interrupt pin, asynchronous to clk.
- int_en  in  1  global interrupt enable from the control register.
- boundary  in  1  fetch unit is at a single-word instruction boundary (not mid two-word fetch, not in branch/wait).
- stall_in  in  1  pipeline stall; no request is issued while high.
- int_clr  in  1  acknowledge from fetch unit; vector load done.
- rti_done  in  1  one-cycle pulse when RTI retires (PC restored).
- intr  out  1  interrupt request to fetch unit.
- in_service  out  1  handler currently executing.
- pending  out  1  an un-issued request is latched.
- lost_cnt  out  LOST_W  count of coalesced/dropped events, saturating.

Behaviour:
- Reset: all flops clear; `intr`=0, `in_service`=0, `pending`=0, `lost_cnt`=0, state IDLE.
- `intr` is a registered output ANDed with `~reset`, so it is never high in a reset cycle. Reset mid-handshake abandons the request.
- Sync and event detection:
  - `s` is the last synchroniser stage; `s_d` is `s` delayed one cycle.
  - EDGE_MODE=1: event = `s & ~s_d`.
  - EDGE_MODE=0: event = `s` while in IDLE, or `s` at the `rti_done` cycle.
- Queue bit `q` holds at most one request latched during SERVICE.
- States: IDLE, ARMED, REQ, SERVICE.
- IDLE:
  - On event, go to ARMED and set `pending`=1.
  - Events are latched even when `int_en`=0.
- ARMED:
  - When `int_en & boundary & ~stall_in` are sampled high, go to REQ; `intr`=1 from the next cycle.
  - A further event increments `lost_cnt`.
- REQ:
  - `intr` is held high until `int_clr` is sampled high.
  - On `int_clr`, go to SERVICE: `intr`=0, `pending`=0, `in_service`=1, all in the next cycle.
  - `intr` ignores `stall_in`/`boundary` changes while in REQ; the request is never withdrawn.
  - An event in REQ increments `lost_cnt`.
- SERVICE:
  - An event sets `q` and `pending`=1.
  - An event while `q`=1 increments `lost_cnt`.
  - On `rti_done`: `in_service`=0; go to ARMED if `q` (clear `q`), else IDLE.
  - Event coincident with `rti_done` and `q`=0: go to ARMED with `pending`=1.
  - Event coincident with `rti_done` and `q`=1: go to ARMED and increment `lost_cnt`.
- `int_clr` outside REQ and `rti_done` outside SERVICE are ignored.
- Latency (SYNC_STAGES=2, EDGE_MODE=1, enables high):
  - `irq_in` first sampled high at edge E0.
  - `s` is high after E1; the event is seen in the following cycle.
  - ARMED after E2; `intr` high after E3.
  - General formula: `intr` = E0 + SYNC_STAGES + 1.
- `lost_cnt` saturates at 2^LOST_W−1 and never wraps.
- A new request cannot issue in the same cycle as `rti_done`; the minimum spacing is ARMED→REQ, i.e. one cycle.

Test Plan:
1. Reset, then raise `irq_in` with `boundary`=1, `int_en`=1, `stall_in`=0 → `intr`=1 exactly 3 cycles after the first sampling edge; `int_clr` pulse → next cycle `intr`=0, `in_service`=1, `pending`=0.
2. Event with `boundary`=0 for 5 cycles, then `boundary`=1 → `intr` stays 0 and `pending`=1 during the wait; `intr` rises 1 cycle after `boundary`. Repeat with `stall_in`=1 and `int_en`=0 as the blockers → same result.
3. Two edges during SERVICE, then `rti_done` → `q` set by the first edge, `lost_cnt`=1 from the second; state goes to ARMED and `intr` reasserts next cycle.
4. 20 edges while held in ARMED with `int_en`=0 → `lost_cnt`=15 (saturated, LOST_W=4), `pending`=1.
5. Assert `reset` while in REQ with `intr`=1 → `intr`=0 in the reset cycle, all outputs 0 after; the next edge after reset re-issues normally.
6. EDGE_MODE=0, `irq_in` held high through `rti_done` → re-arm and a second `intr`; with `irq_in` low at `rti_done` → return to IDLE with `intr`=0.
